// File: rtl/pxi_pkg.sv
// pxi_pkg: shared transfer-FSM encoding and default constants for the PXI DMA read buffer.
package pxi_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} xfer_state_t;
    localparam logic [15:0] FILL_WORD_DEFAULT = 16'hDEAD;
endpackage

// File: rtl/pxi_dpram.sv
// pxi_dpram: simple dual-port storage, registered write port, asynchronous read port.
module pxi_dpram #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/pxi_dma_rd_buf.sv
// pxi_dma_rd_buf: FWFT acquisition buffer drained by counted DMA read transfers.
// Define PXI_DMA_UNDERRUN_FILL_EN to present FILL_WORD on underrun reads.
module pxi_dma_rd_buf
    import pxi_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 9,
    parameter logic [15:0] FILL_WORD  = FILL_WORD_DEFAULT
) (
    input  logic                  LCLK,
    input  logic                  RST,
    input  logic                  WR_EN,
    input  logic [15:0]           WR_DATA,
    input  logic                  ARM,
    input  logic [15:0]           XFER_LEN,
    input  logic                  DMAR_N,
    input  logic                  CLR_ERR,
    output logic [15:0]           RD_DATA,
    output logic                  RD_OE,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [DEPTH_LOG2:0]   LEVEL,
    output logic                  XFER_BUSY,
    output logic                  XFER_DONE,
    output logic                  OVF,
    output logic                  UDF
);
`ifdef PXI_DMA_UNDERRUN_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif
    localparam int AW = DEPTH_LOG2;

    xfer_state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d, head_q, head_d, ram_rd;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        ovf_q, ovf_d, udf_q, udf_d;
    logic        rd_cyc, pop, push, udf_set, ovf_set;

    pxi_dpram #(.AW(AW), .DW(16)) u_ram (
        .clk   (LCLK),
        .we    (push),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (WR_DATA),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (ram_rd)
    );

    assign LEVEL     = wr_ptr_q - rd_ptr_q;
    assign EMPTY     = LEVEL == '0;
    assign FULL      = LEVEL == {1'b1, {AW{1'b0}}};
    assign rd_cyc    = ~DMAR_N & (state_q == XFER);
    assign pop       = rd_cyc & ~EMPTY;
    assign udf_set   = rd_cyc & EMPTY;
    // A pop frees the slot the write lands in, so full+pop still accepts the write.
    assign push      = WR_EN & (~FULL | pop);
    assign ovf_set   = WR_EN & FULL & ~pop;
    assign RD_OE     = rd_cyc;
    assign XFER_BUSY = state_q != IDLE;
    assign XFER_DONE = state_q == DONE;
    assign OVF       = ovf_q;
    assign UDF       = udf_q;
    // head_q holds the last popped word for when the buffer has nothing to show.
    assign RD_DATA   = ~EMPTY ? ram_rd : (udf_set && FILL_EN) ? FILL_WORD : head_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        head_d   = pop ? ram_rd : head_q;
        ovf_d    = ovf_set | (ovf_q & ~CLR_ERR);
        udf_d    = udf_set | (udf_q & ~CLR_ERR);
        case (state_q)
            IDLE: if (ARM && XFER_LEN != '0) begin
                state_d = XFER;
                cnt_d   = XFER_LEN;
            end
            XFER: if (rd_cyc) begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd1) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge LCLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end
endmodule

// File: tb/tb_pxi_dma_rd_buf.sv
// tb_pxi_dma_rd_buf: vector table plus queue scoreboard for the PXI DMA read buffer.
module tb_pxi_dma_rd_buf;
    localparam int DEPTH = 512;
`ifdef PXI_DMA_UNDERRUN_FILL_EN
    localparam bit FILL_ON = 1'b1;
`else
    localparam bit FILL_ON = 1'b0;
`endif

    typedef struct {
        logic        wr;
        logic [15:0] wd;
        logic        arm;
        logic [15:0] len;
        logic        dmar_n;
        logic [15:0] e_data;
        logic        e_oe;
        logic        e_done;
        logic [9:0]  e_level;
        logic        e_empty;
    } vec_t;

    logic        LCLK = 1'b0;
    logic        RST, WR_EN, ARM, DMAR_N, CLR_ERR;
    logic [15:0] WR_DATA, XFER_LEN, RD_DATA;
    logic        RD_OE, FULL, EMPTY, XFER_BUSY, XFER_DONE, OVF, UDF;
    logic [9:0]  LEVEL;

    int          n_cmp = 0, n_err = 0;
    logic [15:0] sb[$];
    int          m_st = 0, m_cnt = 0;
    logic        m_ovf = 1'b0, m_udf = 1'b0;
    logic [15:0] m_last = 16'd0;
    logic        s_rd, s_pop, s_und;

    always #5 LCLK = ~LCLK;

    pxi_dma_rd_buf dut (
        .LCLK(LCLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .ARM(ARM),
        .XFER_LEN(XFER_LEN), .DMAR_N(DMAR_N), .CLR_ERR(CLR_ERR), .RD_DATA(RD_DATA),
        .RD_OE(RD_OE), .FULL(FULL), .EMPTY(EMPTY), .LEVEL(LEVEL), .XFER_BUSY(XFER_BUSY),
        .XFER_DONE(XFER_DONE), .OVF(OVF), .UDF(UDF)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic wr, input logic [15:0] wd, input logic rd_n,
                         input logic arm = 1'b0, input logic [15:0] len = 16'd0,
                         input logic clr = 1'b0);
        WR_EN = wr; WR_DATA = wd; DMAR_N = rd_n; ARM = arm; XFER_LEN = len; CLR_ERR = clr;
    endtask

    // Sample outputs mid-cycle against the scoreboard model.
    task automatic step_a();
        logic [15:0] exp_d;
        @(negedge LCLK);
        s_rd  = !DMAR_N && m_st == 1;
        s_pop = s_rd && sb.size() != 0;
        s_und = s_rd && sb.size() == 0;
        exp_d = sb.size() != 0 ? sb[0] : (s_und && FILL_ON) ? 16'hDEAD : m_last;
        chk("rd_oe", RD_OE, s_rd);
        chk("level", LEVEL, sb.size());
        chk("empty", EMPTY, sb.size() == 0);
        chk("full", FULL, sb.size() == DEPTH);
        chk("busy", XFER_BUSY, m_st != 0);
        chk("done", XFER_DONE, m_st == 2);
        chk("ovf", OVF, m_ovf);
        chk("udf", UDF, m_udf);
        chk("rd_data", RD_DATA, exp_d);
    endtask

    // Advance the model across the clock edge.
    task automatic step_b();
        logic acc, ovs;
        @(posedge LCLK);
        acc = WR_EN && (sb.size() < DEPTH || s_pop);
        ovs = WR_EN && sb.size() == DEPTH && !s_pop;
        if (s_pop) m_last = sb.pop_front();
        if (acc) sb.push_back(WR_DATA);
        m_ovf = ovs || (m_ovf && !CLR_ERR);
        m_udf = s_und || (m_udf && !CLR_ERR);
        case (m_st)
            0: if (ARM && XFER_LEN != 16'd0) begin m_st = 1; m_cnt = XFER_LEN; end
            1: if (s_rd) begin m_cnt--; if (m_cnt == 0) m_st = 2; end
            default: m_st = 0;
        endcase
        #1;
    endtask

    task automatic cyc(input logic wr, input logic [15:0] wd, input logic rd_n,
                       input logic arm = 1'b0, input logic [15:0] len = 16'd0,
                       input logic clr = 1'b0);
        drive(wr, wd, rd_n, arm, len, clr);
        step_a();
        step_b();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        drive(1'b0, 16'd0, 1'b1);
        @(posedge LCLK); #1;
        chk("rst_empty", EMPTY, 1);
        chk("rst_level", LEVEL, 0);
        chk("rst_full", FULL, 0);
        chk("rst_busy", XFER_BUSY, 0);
        chk("rst_done", XFER_DONE, 0);
        chk("rst_ovf", OVF, 0);
        chk("rst_udf", UDF, 0);
        chk("rst_rd_data", RD_DATA, 0);
        RST = 1'b0;
        sb.delete();
        m_st = 0; m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0; m_last = 16'd0;
    endtask

    initial begin
        vec_t tv[11];
        RST = 1'b1;
        drive(1'b0, 16'd0, 1'b1);
        do_reset();

        // Basic transfer: four writes, ARM len 4, four reads, done pulse.
        tv[0]  = '{1'b1, 16'd1, 1'b0, 16'd0, 1'b1, 16'd0, 1'b0, 1'b0, 10'd0, 1'b1};
        tv[1]  = '{1'b1, 16'd2, 1'b0, 16'd0, 1'b1, 16'd1, 1'b0, 1'b0, 10'd1, 1'b0};
        tv[2]  = '{1'b1, 16'd3, 1'b0, 16'd0, 1'b1, 16'd1, 1'b0, 1'b0, 10'd2, 1'b0};
        tv[3]  = '{1'b1, 16'd4, 1'b0, 16'd0, 1'b1, 16'd1, 1'b0, 1'b0, 10'd3, 1'b0};
        tv[4]  = '{1'b0, 16'd0, 1'b1, 16'd4, 1'b1, 16'd1, 1'b0, 1'b0, 10'd4, 1'b0};
        tv[5]  = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 16'd1, 1'b1, 1'b0, 10'd4, 1'b0};
        tv[6]  = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 16'd2, 1'b1, 1'b0, 10'd3, 1'b0};
        tv[7]  = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 16'd3, 1'b1, 1'b0, 10'd2, 1'b0};
        tv[8]  = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 16'd4, 1'b1, 1'b0, 10'd1, 1'b0};
        tv[9]  = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b1, 16'd4, 1'b0, 1'b1, 10'd0, 1'b1};
        tv[10] = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b1, 16'd4, 1'b0, 1'b0, 10'd0, 1'b1};
        foreach (tv[i]) begin
            drive(tv[i].wr, tv[i].wd, tv[i].dmar_n, tv[i].arm, tv[i].len);
            step_a();
            chk($sformatf("tv%0d_data", i), RD_DATA, tv[i].e_data);
            chk($sformatf("tv%0d_oe", i), RD_OE, tv[i].e_oe);
            chk($sformatf("tv%0d_done", i), XFER_DONE, tv[i].e_done);
            chk($sformatf("tv%0d_level", i), LEVEL, tv[i].e_level);
            chk($sformatf("tv%0d_empty", i), EMPTY, tv[i].e_empty);
            step_b();
        end

        // Overflow, clear, then full write+read across the pointer wrap.
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 16'($urandom), 1'b1);
        cyc(1'b1, 16'hBEEF, 1'b1);
        drive(1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 1'b1);
        step_a();
        chk("ovf_set", OVF, 1);
        chk("ovf_level", LEVEL, DEPTH);
        step_b();
        drive(1'b0, 16'd0, 1'b1);
        step_a();
        chk("ovf_clr", OVF, 0);
        step_b();
        cyc(1'b0, 16'd0, 1'b1, 1'b1, 16'(DEPTH + 3));
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'(16'h0100 + k), 1'b0);
            step_a();
            chk("wrap_level", LEVEL, DEPTH);
            step_b();
        end
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 16'd0, 1'b0);
        cyc(1'b0, 16'd0, 1'b1);
        cyc(1'b0, 16'd0, 1'b1);

        // Underrun reads, write+read on empty, set beats clear.
        do_reset();
        cyc(1'b1, 16'h1234, 1'b1);
        cyc(1'b0, 16'd0, 1'b1, 1'b1, 16'd4);
        cyc(1'b0, 16'd0, 1'b0);
        drive(1'b0, 16'd0, 1'b0);
        step_a();
        chk("udf_data", RD_DATA, FILL_ON ? 16'hDEAD : 16'h1234);
        step_b();
        cyc(1'b1, 16'h5678, 1'b0, 1'b0, 16'd0, 1'b1);
        drive(1'b0, 16'd0, 1'b0);
        step_a();
        chk("udf_hold", UDF, 1);
        chk("wr_on_udf", RD_DATA, 16'h5678);
        step_b();
        drive(1'b0, 16'd0, 1'b1);
        step_a();
        chk("udf_done", XFER_DONE, 1);
        step_b();
        cyc(1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 1'b1);
        cyc(1'b0, 16'd0, 1'b1);

        // Ignored ARMs, reads outside XFER, reset mid-transfer.
        do_reset();
        cyc(1'b1, 16'h00A1, 1'b1);
        cyc(1'b1, 16'h00A2, 1'b1);
        cyc(1'b0, 16'd0, 1'b0);
        cyc(1'b0, 16'd0, 1'b1, 1'b1, 16'd0);
        drive(1'b0, 16'd0, 1'b1);
        step_a();
        chk("len0_idle", XFER_BUSY, 0);
        step_b();
        cyc(1'b0, 16'd0, 1'b1, 1'b1, 16'd2);
        cyc(1'b0, 16'd0, 1'b0);
        cyc(1'b0, 16'd0, 1'b1, 1'b1, 16'd5);
        drive(1'b0, 16'd0, 1'b1);
        step_a();
        chk("arm_xfer_busy", XFER_BUSY, 1);
        chk("arm_xfer_level", LEVEL, 1);
        step_b();
        cyc(1'b0, 16'd0, 1'b0);
        cyc(1'b0, 16'd0, 1'b1);
        cyc(1'b0, 16'd0, 1'b1);
        cyc(1'b1, 16'h00B1, 1'b1);
        cyc(1'b1, 16'h00B2, 1'b1);
        cyc(1'b0, 16'd0, 1'b1, 1'b1, 16'd3);
        cyc(1'b0, 16'd0, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 16'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pxi_dma_rd_buf.md
PXI_DMA_RD_BUF -- requirements
Module: pxi_dma_rd_buf

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 9, which sets buffer depth to 2^DEPTH_LOG2 words.
REQ-002 SHALL have parameter FILL_WORD, default 16'hDEAD, which is the underrun fill value.
REQ-003 SHALL have ports, one per line as name, direction, width, meaning:
- LCLK  in  1  local bus clock; sole clock; all logic on its rising edge.
- RST  in  1  reset; synchronous, active-high.
- WR_EN  in  1  acquisition-side write strobe.
- WR_DATA  in  16  acquisition sample word.
- ARM  in  1  one-cycle pulse from the decoded register-write strobe; starts a transfer.
- XFER_LEN  in  16  transfer length in words; sampled on ARM.
- DMAR_N  in  1  active-low DMA read strobe from the address decoder; one word per low cycle.
- CLR_ERR  in  1  clears the sticky error flags.
- RD_DATA  out  16  head-of-buffer word presented to the LD read driver.
- RD_OE  out  1  drive enable for LD.
- FULL  out  1  buffer full.
- EMPTY  out  1  buffer empty.
- LEVEL  out  DEPTH_LOG2+1  number of stored words.
- XFER_BUSY  out  1  transfer in progress.
- XFER_DONE  out  1  one-cycle pulse at transfer end.
- OVF  out  1  sticky overflow flag.
- UDF  out  1  sticky underrun flag.

Function
REQ-004 SHALL be a first-word-fall-through buffer: RD_DATA equals the oldest stored word in the same cycle it becomes the head.
REQ-005 SHALL have a write latency of 1 cycle: a word written on cycle N is visible on RD_DATA and LEVEL from cycle N+1.
REQ-006 SHALL use FSM states IDLE, XFER and DONE.
REQ-007 SHALL move IDLE to XFER on ARM=1 with XFER_LEN!=0, loading the remaining-word counter with XFER_LEN.
REQ-008 SHALL ignore ARM when XFER_LEN=0 or when the FSM is in XFER or DONE.
REQ-009 SHALL, in XFER, treat each cycle with DMAR_N=0 as a read: pop one word and decrement the remaining-word counter.
REQ-010 SHALL enter DONE after the read that brings the counter to 0, assert XFER_DONE for exactly the DONE cycle, then return to IDLE.
REQ-011 SHALL drive RD_OE = ~DMAR_N & (state==XFER), combinationally, for the tristate driver.
REQ-012 SHALL, outside XFER, never pop on DMAR_N and keep RD_OE low.
REQ-013 SHALL keep XFER_BUSY high in XFER and DONE.
REQ-014 SHALL treat a read while EMPTY as an underrun: no pop, UDF set, counter still decrements, RD_DATA per REQ-024.
REQ-015 SHALL count a write and a read in the same cycle on an empty buffer as an underrun; the written word is stored.
REQ-016 SHALL drop a write when FULL and no pop occurs in that cycle, and set OVF.
REQ-017 SHALL accept both the write and the pop when a write and a pop occur in the same cycle while FULL; LEVEL is unchanged.
REQ-018 SHALL wrap pointers modulo 2^DEPTH_LOG2 and derive LEVEL from (DEPTH_LOG2+1)-bit pointers; FULL = (LEVEL==2^DEPTH_LOG2).
REQ-019 SHALL clear OVF and UDF on CLR_ERR; a same-cycle set has priority over the clear.

Reset
REQ-020 SHALL, on RST=1, zero both pointers and set the FSM to IDLE.
REQ-021 SHALL, on RST=1, drive EMPTY=1, LEVEL=0, FULL=0, XFER_BUSY=0, XFER_DONE=0, OVF=0, UDF=0 and RD_DATA=0.
REQ-022 SHALL, on RST=1 during XFER, abort the transfer without asserting XFER_DONE and discard the stored data.

Configuration
REQ-023 SHALL recognise the macro PXI_DMA_UNDERRUN_FILL_EN.
REQ-024 SHALL drive RD_DATA=FILL_WORD during an underrun read when PXI_DMA_UNDERRUN_FILL_EN is defined; otherwise RD_DATA SHALL hold the last popped word (0 after reset).

Structure
REQ-025 SHALL take the FSM state encoding and the FILL_WORD default from a shared package, pxi_pkg.
REQ-026 SHALL place storage in one sub-module, pxi_dpram: simple dual-port, one write port and one read port, registered write; the FWFT head register stays in the top level.

Verification
REQ-027 Write 4 words (1,2,3,4), ARM with LEN=4, hold DMAR_N low for 4 cycles -> RD_DATA 1,2,3,4 with RD_OE high, XFER_DONE pulses once, EMPTY=1.
REQ-028 Fill 512 words, then write 1 more -> word dropped, OVF=1, LEVEL=512; CLR_ERR -> OVF=0.
REQ-029 ARM with LEN=3 and 1 word stored, read 3 -> UDF=1, RD_DATA=16'hDEAD on the underrun cycles (macro defined) or the held word (macro undefined), XFER_DONE pulses.
REQ-030 FULL with a simultaneous write and read -> LEVEL stays 512, order preserved across the pointer wrap.
REQ-031 ARM with LEN=0, and ARM during XFER -> no state change; RST mid-transfer -> IDLE, no XFER_DONE, LEVEL=0.
